vrased_reset_ctrl: RTL
======================

Name: vrased_reset_ctrl

Overview:
- Downstream consumer of the per-monitor violation resets: dma_detect, atomicity monitor and key-access monitor.
- Merges them into one stretched system reset for the openMSP430 core.
- Records which monitors fired in a sticky cause register and keeps a saturating violation count.
- Guarantees the core reset pulse has a minimum width regardless of how briefly a monitor asserts, and re-fires reset if a monitor stays stuck in its kill state.

Parameters:
- RST_CYCLES, 16: minimum sys_reset pulse width in clk cycles (>=1).
- TIMEOUT, 64: cycles in RECOVER with any violation still high before reset is re-fired (>=1).
- CNT_W, 8: width of viol_cnt.

Ports:
- clk  input  1  system clock (all logic on posedge).
- por  input  1  synchronous active-high reset.
- viol_dma  input  1  reset output of dma_detect.
- viol_atom  input  1  reset output of atomicity monitor.
- viol_key  input  1  reset output of key-access monitor.
- cause_clr  input  1  single-cycle software acknowledge, clears cause.
- sys_reset  output  1  registered reset to the core, active high.
- cause  output  3  sticky bits {key, atom, dma}.
- viol_cnt  output  CNT_W  saturating count of reset events.
- armed  output  1  high when in ARMED.

Behaviour:
- All outputs registered; viol_any = viol_dma | viol_atom | viol_key.
- States: HOLD, RECOVER, ARMED. Two internal counters:
  - hold_cnt: $clog2(RST_CYCLES) bits, minimum 1.
  - tmo_cnt: $clog2(TIMEOUT) bits, minimum 1.
- por = 1 (synchronous, overrides everything):
  - state = HOLD, hold_cnt = RST_CYCLES-1.
  - sys_reset = 1, cause = 0, viol_cnt = 0, armed = 0.
  - After por falls, sys_reset stays 1 for exactly RST_CYCLES further cycles.
  - Power-up counts as a reset but is not a violation; viol_cnt is not incremented.
- ARMED:
  - sys_reset = 0, armed = 1.
  - If viol_any: next state HOLD, hold_cnt = RST_CYCLES-1, cause |= inputs, viol_cnt += 1 (saturating at all-ones).
  - sys_reset rises in the cycle after the violation is sampled; latency is 1.
- HOLD:
  - sys_reset = 1, armed = 0.
  - If hold_cnt == 0: next state RECOVER, tmo_cnt = 0. Otherwise hold_cnt decrements.
  - Violation inputs seen during HOLD are OR'd into cause but do not increment viol_cnt.
  - Total HOLD residency is exactly RST_CYCLES cycles.
- RECOVER:
  - sys_reset = 0, armed = 0. The core runs and is expected to reach the reset handler so the monitors release.
  - If !viol_any: next state ARMED.
  - Else if tmo_cnt == TIMEOUT-1: next state HOLD, hold_cnt reloaded, viol_cnt += 1 (saturating), cause |= inputs.
  - Else tmo_cnt increments.
  - A monitor deasserting on the same cycle tmo_cnt reaches TIMEOUT-1 goes to ARMED; the release wins.
- cause_clr:
  - Honoured only in ARMED; ignored in HOLD and RECOVER.
  - If asserted with viol_any in ARMED, cause <= current inputs: new bits win, old bits are cleared.
- viol_cnt saturation: at 2^CNT_W-1, further events leave it unchanged; cause still updates.
- A simultaneous multi-monitor violation sets several cause bits and counts as one event.
- por during HOLD or RECOVER aborts immediately to the por state; cause and viol_cnt are lost.

Test Plan:
- Power-up: por high 3 cycles then low, all viol low -> sys_reset = 1 for 16 cycles after por falls, then 0. armed = 1 one cycle later. viol_cnt = 0, cause = 0.
- Single-cycle viol_dma pulse in ARMED -> sys_reset = 1 for exactly 16 cycles starting the next cycle. cause = 3'b001, viol_cnt = 1, then RECOVER -> ARMED.
- viol_atom and viol_key high together in ARMED, viol_dma pulsed mid-HOLD -> cause = 3'b111, viol_cnt = 1.
- viol_key held high indefinitely -> reset pulses of 16 cycles separated by 64 low cycles. viol_cnt increments each pulse. With CNT_W = 2 it saturates at 3.
- In ARMED with cause = 3'b001, cause_clr pulsed alone -> cause = 0. cause_clr pulsed together with viol_atom -> cause = 3'b010. cause_clr during HOLD -> cause unchanged.
- por asserted at HOLD cycle 5 and RECOVER cycle 10 -> immediate return to por state. cause = 0, viol_cnt = 0, then a full 16-cycle sys_reset.

Source files
------------

// File: rtl/vrased_reset_ctrl.sv
// ---------------------------------------------------------------------------
// vrased_reset_ctrl: merges VRASED monitor violations into a stretched core
// reset with sticky cause, saturating event count and stuck-monitor re-fire.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vrased_reset_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             por,
  input  logic             viol_dma,
  input  logic             viol_atom,
  input  logic             viol_key,
  input  logic             cause_clr,
  output logic             sys_reset,
  output logic [2:0]       cause,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             armed
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RECOVER = 2'd1,
    ARMED   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [2:0]         cause_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               fire;

  logic [2:0] viol_in;
  logic       viol_any;

  assign viol_in  = {viol_key, viol_atom, viol_dma};
  assign viol_any = |viol_in;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    tmo_nxt   = tmo_cnt;
    cause_nxt = cause;
    fire      = 1'b0;
    case (state)
      HOLD: begin
        // Late or repeated violations are recorded but are not new events.
        cause_nxt = cause | viol_in;
        if (hold_cnt == '0) begin
          state_nxt = RECOVER;
          tmo_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      RECOVER: begin
        // A release on the final timeout cycle wins over the re-fire.
        if (!viol_any) begin
          state_nxt = ARMED;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_INIT;
          cause_nxt = cause | viol_in;
          fire      = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      ARMED: begin
        cause_nxt = cause_clr ? viol_in : (cause | viol_in);
        if (viol_any) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_INIT;
          fire      = 1'b1;
        end
      end
      default: begin
        state_nxt = HOLD;
        hold_nxt  = HOLD_INIT;
      end
    endcase
  end

  assign cnt_nxt = (fire && (viol_cnt != CNT_MAX)) ? viol_cnt + CNT_W'(1) : viol_cnt;

  always_ff @(posedge clk) begin
    if (por) begin
      state     <= HOLD;
      hold_cnt  <= HOLD_INIT;
      tmo_cnt   <= '0;
      sys_reset <= 1'b1;
      cause     <= '0;
      viol_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      tmo_cnt   <= tmo_nxt;
      sys_reset <= (state_nxt == HOLD);
      cause     <= cause_nxt;
      viol_cnt  <= cnt_nxt;
      armed     <= (state_nxt == ARMED);
    end
  end

endmodule

`default_nettype wire
